// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with one-entry pending redirect and optional return-address stack
// Define PC_SEQUENCER_RAS_EN to compile in the return-address stack.
module pc_sequencer #(
    parameter int                    PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                    PC_STEP      = 1,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                call,
    input  logic [PC_WIDTH-1:0] ret_addr_in,
    input  logic                ret,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_error
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    logic                advance;
    logic                req_valid;
    logic [PC_WIDTH-1:0] req_target;
    logic                pend_valid;
    logic [PC_WIDTH-1:0] pend_target;

    assign advance = fetch_valid & fetch_ready & ~stall;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int                PW      = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [PW:0]       CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]       CNT_MAX = (PW + 1)'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]       ras_wp;
    logic [PW:0]         ras_cnt;
    logic [PW-1:0]       ras_top;
    logic                pop_ok;
    logic                pop_bad;
    logic                push;

    assign ras_top   = ras_wp - PTR_ONE;
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_MAX);
    assign pop_ok    = ret & ~ras_empty;
    assign pop_bad   = ret & ras_empty;
    // A successful return outranks a same-cycle call, so that call neither redirects nor pushes.
    assign push      = call & ~pop_ok;

    assign req_valid  = pop_ok | push | branch_taken;
    assign req_target = pop_ok ? ras_mem[ras_top] : branch_target;

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_wp] <= ret_addr_in;
        end
    end

    // When full, ras_wp already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_wp    <= '0;
            ras_cnt   <= '0;
            ras_error <= 1'b0;
        end else begin
            if (pop_ok) begin
                ras_wp  <= ras_top;
                ras_cnt <= ras_cnt - CNT_ONE;
            end else if (push) begin
                ras_wp <= ras_wp + PTR_ONE;
                if (ras_full) begin
                    ras_error <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_ONE;
                end
            end
            if (pop_bad) begin
                ras_error <= 1'b1;
            end
        end
    end
`else
    logic unused_ras;

    assign unused_ras = ^{ret, ret_addr_in, RAS_DEPTH[0]};
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_error  = 1'b0;
    assign req_valid  = call | branch_taken;
    assign req_target = branch_target;
`endif

    // A fresh redirect beats a pending one; pending is consumed by any advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            fetch_valid <= 1'b1;
            if (advance) begin
                pend_valid <= 1'b0;
                if (req_valid) begin
                    pc <= req_target;
                end else if (pend_valid) begin
                    pc <= pend_target;
                end else begin
                    pc <= pc + STEP;
                end
            end else if (req_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= req_target;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter PC_STEP, default 1, sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC; no advance.
REQ-008 branch_taken  in  1  redirect request to branch_target.
REQ-009 branch_target  in  PC_WIDTH  redirect destination for branch or call.
REQ-010 call  in  1  redirect to branch_target and push ret_addr_in.
REQ-011 ret_addr_in  in  PC_WIDTH  return address pushed on call.
REQ-012 ret  in  1  redirect to popped RAS top.
REQ-013 fetch_ready  in  1  instruction memory accepts pc this cycle.
REQ-014 fetch_valid  out  1  pc is a valid fetch address.
REQ-015 pc  out  PC_WIDTH  current fetch address.
REQ-016 ras_empty, ras_full  out  1 each  RAS occupancy flags.
REQ-017 ras_error  out  1  sticky overflow/underflow flag.

Function
REQ-018 advance = fetch_valid & fetch_ready & ~stall; pc SHALL change only on a cycle where advance=1.
REQ-019 On advance with no redirect, applied or pending, pc SHALL become pc+PC_STEP modulo 2^PC_WIDTH (wrap from all-ones region to low addresses, no flag).
REQ-020 Redirect priority in the same cycle: ret > call > branch_taken; lower-priority requests that cycle SHALL be discarded.
REQ-021 Redirect on an advance cycle SHALL take effect on the next edge (pc = target one cycle later).
REQ-022 Redirect on a non-advance cycle SHALL be captured in a one-entry pending register; a later redirect before application SHALL overwrite it; it SHALL be applied on the next advance, then cleared.
REQ-023 Pending and a new same-cycle redirect on an advance cycle: new redirect SHALL win.
REQ-024 call SHALL push ret_addr_in on the cycle asserted, independent of advance.
REQ-025 ret SHALL pop on the cycle asserted; target = pre-pop top.
REQ-026 Push when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, set ras_error.
REQ-027 Pop when empty SHALL not redirect (treated as no request), leave the stack unchanged, and set ras_error.
REQ-028 ras_error SHALL clear only on reset.

Reset
REQ-029 reset_n=0 SHALL asynchronously force pc=RESET_VECTOR, fetch_valid=0, pending clear, RAS empty (ras_empty=1, ras_full=0), ras_error=0.
REQ-030 fetch_valid SHALL go to 1 on the first rising edge after reset_n deasserts, with pc=RESET_VECTOR.
REQ-031 Reset mid-redirect or mid-stall SHALL discard all pending state.

Configuration
REQ-032 Macro PC_SEQUENCER_RAS_EN SHALL compile in the RAS.
REQ-033 With PC_SEQUENCER_RAS_EN defined, REQ-024..REQ-028 apply.
REQ-034 With PC_SEQUENCER_RAS_EN undefined, there SHALL be no RAS storage; call acts as branch_taken; ret is ignored; ras_empty=1, ras_full=0, ras_error=0 constantly.

Verification
REQ-035 Release reset, fetch_ready=1, no redirects -> pc 0,1,2,3 on successive cycles, fetch_valid=1 from the first edge.
REQ-036 PC_WIDTH=8, pc=8'hFF, advance -> pc=8'h00, no error.
REQ-037 stall=1 plus branch_taken to 0x40 for one cycle, stall released 3 cycles later -> pc holds, then 0x40 on the first advance.
REQ-038 call target 0x100, ret_addr 0x11, then ret -> pc 0x100, then 0x11, ras_empty=1 afterwards.
REQ-039 RAS_DEPTH=4, five calls (ret_addr 1..5), five rets -> returns 5,4,3,2 then no redirect; ras_error=1.
REQ-040 Assert reset_n=0 mid-stall with pending redirect -> pc=RESET_VECTOR immediately; after release, sequential from RESET_VECTOR.
